dut_cordic_vectoring: RTL and testbench
=======================================

Name: dut_cordic_vectoring

Overview:
Vectoring-mode CORDIC, the inverse of the task-5 rotation CORDIC: it takes a Cartesian sample (X, Y) and returns the polar angle atan2(Y, X) and the magnitude.
- Fully pipelined, one micro-rotation per stage, one sample per clock.
- Angle output uses the same sfix20_En12 format as the rotation block's angle input.
- X/Y inputs use the same 15-bit width as the rotation block's outputs, so the two blocks chain back-to-back for round-trip checks.

Parameters:
ITERATIONS, 16, number of micro-rotation stages (valid 8..18); sets latency and accuracy.
GUARD_W, 4, extra LSBs appended to internal X/Y datapath below the input LSB.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
x_in  input  15  signed X sample, sfix15_En13
y_in  input  15  signed Y sample, sfix15_En13
enable_in  input  1  x_in/y_in valid this cycle
angle_out  output  20  atan2(y,x), radians, sfix20_En12, range [-pi, +pi]
mag_out  output  16  magnitude, ufix16_En13
valid_out  output  1  angle_out/mag_out updated this cycle

Behaviour:
- Reset:
  - One clock; synchronous, active-high; all flops on clk rising edge.
  - While reset is high at a clock edge: all pipeline valid bits, valid_out, angle_out and mag_out are cleared to 0.
  - In-flight samples are discarded.
  - valid_out stays 0 until a sample entered after reset deassertion reaches the output.
- Internal widths:
  - X/Y datapath: signed 15+2+GUARD_W bits. Sign-extend by 2, then append GUARD_W zero LSBs, so negation and gain growth cannot overflow.
  - Angle accumulator Z: signed 24 bits, En20.
  - atan(2^-i) ROM: constants rounded to nearest at En20, i = 0..ITERATIONS-1.
- Stage 0 (pre-rotation): if x_in < 0, then X = -x, Y = -y, Z = +pi when y_in >= 0, else Z = -pi. Otherwise X = x, Y = y, Z = 0.
- Stage i (1..ITERATIONS), using k = i-1:
  - If Y >= 0: X += Y>>>k, Y -= X>>>k, Z += atan(2^-k).
  - Else: X -= Y>>>k, Y += X>>>k, Z -= atan(2^-k).
  - All updates use the previous-stage X/Y. >>> is an arithmetic (floor) shift.
- Output stage:
  - angle_out = Z rounded half-up to En12 (add 2^7, drop 8 LSBs), then saturated to [-12868, +12868].
  - mag_out = X rounded half-up to En13 (drop GUARD_W LSBs), then saturated to 65535.
- Latency: ITERATIONS+2 cycles from an enable_in edge to the matching valid_out. Adds +1 with GAIN_COMP_EN.
- Throughput: 1 sample/clock, no backpressure.
- Bubbles: enable_in low creates a bubble that propagates. angle_out and mag_out register only when the final-stage valid is 1 and hold their value otherwise. valid_out is high for exactly one cycle per accepted sample, in order.
- Boundaries:
  - (0,0) gives angle 0, mag 0.
  - x < 0 with y == 0 gives +pi (12868).
  - x = -16384 negates without overflow.
  - Accuracy at ITERATIONS=16: angle within ±2 LSB, mag within ±4 LSB of ideal.

Optional Feature:
GAIN_COMP_EN
- Defined: one extra pipeline stage multiplies X by 1/K = 0.6072529 (18-bit constant, En17, rounded), so mag_out is the true magnitude. Latency is ITERATIONS+3.
- Undefined: mag_out carries the raw CORDIC gain K ≈ 1.6467603 (for ITERATIONS=16). No multiplier. Latency is ITERATIONS+2.
- angle_out is identical in both builds.

Test Plan:
- x=8192, y=0, single pulse -> valid_out exactly ITERATIONS+2 (or +3) cycles later; angle_out 0 ±2; mag_out 8192 ±4 with GAIN_COMP_EN, 13490 ±4 without.
- x=0, y=8192 -> angle_out 6434 ±2. x=-8192, y=0 -> 12868. x=8192, y=8192 -> 3217 ±2, mag (comp) 11585 ±4.
- x=-8192, y=-8192 -> angle_out -9651 ±2; x=-16384, y=0 -> 12868, mag (comp) 16384 ±4, no overflow.
- 64 back-to-back random samples with enable_in dropped every 5th cycle -> valid_out pattern equals delayed enable_in; all results match a real-valued atan2/hypot model within tolerance; outputs hold during bubbles.
- Reset asserted for 1 cycle mid-stream with 10 samples in flight -> valid_out and outputs 0 the next cycle; none of the 10 emerge; the first post-reset sample appears at nominal latency.
- (0,0) input -> angle_out 0, mag_out 0, valid_out 1 at nominal latency.

Source files
------------

// File: rtl/dut_cordic_vectoring.sv
// Pipelined vectoring-mode CORDIC: (x, y) -> atan2(y, x) in sfix20_En12 and magnitude in ufix16_En13.
// Define GAIN_COMP_EN to add a 1/K scaling stage so mag_out is the true magnitude (+1 cycle latency).
module dut_cordic_vectoring_stage #(
  parameter int DW    = 21,
  parameter int ZW    = 24,
  parameter int SHIFT = 0,
  parameter logic signed [ZW-1:0] ATAN = '0
) (
  input  logic                 clk,
  input  logic signed [DW-1:0] x_prev,
  input  logic signed [DW-1:0] y_prev,
  input  logic signed [ZW-1:0] z_prev,
  output logic signed [DW-1:0] x_next,
  output logic signed [DW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);
  logic signed [DW-1:0] x_sh, y_sh;

  assign x_sh = x_prev >>> SHIFT;
  assign y_sh = y_prev >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!y_prev[DW-1]) begin
      x_next <= x_prev + y_sh;
      y_next <= y_prev - x_sh;
      z_next <= z_prev + ATAN;
    end else begin
      x_next <= x_prev - y_sh;
      y_next <= y_prev + x_sh;
      z_next <= z_prev - ATAN;
    end
  end
endmodule

module dut_cordic_vectoring #(
  parameter int ITERATIONS = 16,
  parameter int GUARD_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] x_in,
  input  logic [14:0] y_in,
  input  logic        enable_in,
  output logic [19:0] angle_out,
  output logic [15:0] mag_out,
  output logic        valid_out
);
  localparam int DW = 17 + GUARD_W;
  localparam int ZW = 24;
`ifdef GAIN_COMP_EN
  localparam int STAGES = ITERATIONS + 1;
`else
  localparam int STAGES = ITERATIONS;
`endif
  localparam logic signed [ZW-1:0] PI_Z    = 24'sd3294199;
  localparam logic signed [ZW-1:0] Z_HALF  = 24'sd128;
  localparam logic signed [15:0]   ANG_MAX = 16'sd12868;
  localparam logic signed [DW:0]   X_HALF  = (DW+1)'(1 << (GUARD_W - 1));
  localparam logic signed [17:0]   MAG_MAX = 18'sd65535;

  // atan(2^-k) at En20, round-to-nearest; beyond k=6 it equals 2^(20-k) after rounding
  function automatic logic signed [ZW-1:0] atan_rom(input int k);
    case (k)
      0:       atan_rom = 24'sd823550;
      1:       atan_rom = 24'sd486170;
      2:       atan_rom = 24'sd256879;
      3:       atan_rom = 24'sd130396;
      4:       atan_rom = 24'sd65451;
      5:       atan_rom = 24'sd32757;
      6:       atan_rom = 24'sd16383;
      default: atan_rom = 24'(32'sd1 <<< (20 - k));
    endcase
  endfunction

  localparam logic signed [ZW-1:0] ATAN_LAST = atan_rom(ITERATIONS - 1);

  logic [STAGES:0]                vld_pipe, zro_pipe;
  logic [ITERATIONS-1:0][DW-1:0]  x_pipe, y_pipe;
  logic [ITERATIONS-1:0][ZW-1:0]  z_pipe;
  logic signed [DW-1:0]           x_ext, y_ext, x0, y0;
  logic signed [ZW-1:0]           z0;

  assign x_ext = {{2{x_in[14]}}, x_in, {GUARD_W{1'b0}}};
  assign y_ext = {{2{y_in[14]}}, y_in, {GUARD_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      zro_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], enable_in};
      zro_pipe <= {zro_pipe[STAGES-1:0], (x_in == 15'd0) && (y_in == 15'd0)};
    end
  end

  // Left half-plane is folded into the right by a 180-degree pre-rotation
  always_ff @(posedge clk) begin
    if (x_in[14]) begin
      x0 <= -x_ext;
      y0 <= -y_ext;
      z0 <= y_in[14] ? -PI_Z : PI_Z;
    end else begin
      x0 <= x_ext;
      y0 <= y_ext;
      z0 <= '0;
    end
  end

  assign x_pipe[0] = x0;
  assign y_pipe[0] = y0;
  assign z_pipe[0] = z0;

  for (genvar i = 1; i < ITERATIONS; i++) begin : g_stage
    dut_cordic_vectoring_stage #(
      .DW(DW), .ZW(ZW), .SHIFT(i - 1), .ATAN(atan_rom(i - 1))
    ) u_stage (
      .clk   (clk),
      .x_prev(x_pipe[i-1]),
      .y_prev(y_pipe[i-1]),
      .z_prev(z_pipe[i-1]),
      .x_next(x_pipe[i]),
      .y_next(y_pipe[i]),
      .z_next(z_pipe[i])
    );
  end

  // Final micro-rotation keeps only X and Z; the residual Y is never consumed
  logic signed [DW-1:0] x_l, y_l, x_cor;
  logic signed [ZW-1:0] z_l, z_cor;

  assign x_l = x_pipe[ITERATIONS-1];
  assign y_l = y_pipe[ITERATIONS-1];
  assign z_l = z_pipe[ITERATIONS-1];

  always_ff @(posedge clk) begin
    if (!y_l[DW-1]) begin
      x_cor <= x_l + (y_l >>> (ITERATIONS - 1));
      z_cor <= z_l + ATAN_LAST;
    end else begin
      x_cor <= x_l - (y_l >>> (ITERATIONS - 1));
      z_cor <= z_l - ATAN_LAST;
    end
  end

  logic signed [DW-1:0] x_fin;
  logic signed [ZW-1:0] z_fin;

`ifdef GAIN_COMP_EN
  localparam logic signed [18:0]    INV_K  = 19'sd79594;
  localparam logic signed [DW+18:0] P_HALF = (DW+19)'(65536);
  logic signed [DW+18:0] prod;
  logic signed [DW-1:0]  x_comp;
  logic signed [ZW-1:0]  z_comp;

  assign prod = (DW+19)'(x_cor) * (DW+19)'(INV_K) + P_HALF;

  always_ff @(posedge clk) begin
    x_comp <= DW'(prod >>> 17);
    z_comp <= z_cor;
  end

  assign x_fin = x_comp;
  assign z_fin = z_comp;
`else
  assign x_fin = x_cor;
  assign z_fin = z_cor;
`endif

  logic signed [ZW-1:0] z_rnd;
  logic signed [15:0]   ang_full, ang_sat;
  logic signed [DW:0]   x_rnd;
  logic signed [17:0]   mag_full;
  logic [15:0]          mag_sat;

  assign z_rnd    = z_fin + Z_HALF;
  assign ang_full = 16'(z_rnd >>> 8);
  assign x_rnd    = {x_fin[DW-1], x_fin} + X_HALF;
  assign mag_full = 18'(x_rnd >>> GUARD_W);

  // (0,0) has no defined direction; the zero flag pins its angle to 0
  always_comb begin
    ang_sat = ang_full;
    if (ang_full > ANG_MAX)       ang_sat = ANG_MAX;
    else if (ang_full < -ANG_MAX) ang_sat = -ANG_MAX;
    if (zro_pipe[STAGES])         ang_sat = '0;
  end

  always_comb begin
    mag_sat = mag_full[15:0];
    if (mag_full[17])             mag_sat = '0;
    else if (mag_full > MAG_MAX)  mag_sat = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      valid_out <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        angle_out <= {{4{ang_sat[15]}}, ang_sat};
        mag_out   <= mag_sat;
      end
    end
  end
endmodule

// File: tb/tb_dut_cordic_vectoring.sv
// Directed-vector and streaming bench for dut_cordic_vectoring (honours GAIN_COMP_EN).
`timescale 1ns/1ps
module tb_dut_cordic_vectoring;
  localparam int ITER = 16;
`ifdef GAIN_COMP_EN
  localparam int LAT  = ITER + 3;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = ITER + 2;
  localparam bit COMP = 1'b0;
`endif
  localparam real K_GAIN = 1.6467602581210656;
  localparam int  NCYC   = 80 + LAT + 2;

  logic        clk = 1'b0;
  logic        reset, enable_in, valid_out;
  logic [14:0] x_in, y_in;
  logic [19:0] angle_out;
  logic [15:0] mag_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x; int y; int ang; int mag_raw; int mag_comp; int atol; int mtol;
  } vec_t;
  vec_t vecs [10];

  dut_cordic_vectoring #(.ITERATIONS(ITER), .GUARD_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .x_in     (x_in),
    .y_in     (y_in),
    .enable_in(enable_in),
    .angle_out(angle_out),
    .mag_out  (mag_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_int(input string name, input int got, input int exp, input int tol);
    n_cmp++;
    if (got > exp + tol || got < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  // One-cycle enable; returns edges until valid_out (capture edge = 1), or -1 on timeout
  task automatic pulse(input int x, input int y, output int lat, output int ang, output int mag);
    lat = -1; ang = 0; mag = 0;
    x_in = 15'(x); y_in = 15'(y); enable_in = 1'b1;
    for (int k = 1; k <= 3 * LAT && lat < 0; k++) begin
      @(posedge clk); #1;
      enable_in = 1'b0;
      if (valid_out) begin
        lat = k;
        ang = int'($signed(angle_out));
        mag = int'(mag_out);
      end
    end
  endtask

  initial begin
    int lat, ang, mag, la, lm, xr, yr, d;
    bit seen;
    bit en_h [NCYC];
    int ea [NCYC];
    int em [NCYC];
    int issued;

    vecs[0] = '{ 8192,      0,      0, 13490,  8192, 2, 4};
    vecs[1] = '{    0,   8192,   6434, 13490,  8192, 2, 4};
    vecs[2] = '{-8192,      0,  12868, 13490,  8192, 0, 4};
    vecs[3] = '{ 8192,   8192,   3217, 19078, 11585, 2, 4};
    vecs[4] = '{-8192,  -8192,  -9651, 19078, 11585, 2, 4};
    vecs[5] = '{-16384,     0,  12868, 26981, 16384, 0, 4};
    vecs[6] = '{    0,      0,      0,     0,     0, 0, 0};
    vecs[7] = '{    0,  -8192,  -6434, 13490,  8192, 2, 4};
    vecs[8] = '{-8192,   8192,   9651, 19078, 11585, 2, 4};
    vecs[9] = '{16383, -16384,  -3217, 38155, 23170, 2, 4};

    reset = 1'b1; enable_in = 1'b0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_valid", int'(valid_out), 0, 0);
    chk_int("rst_angle", int'(angle_out), 0, 0);
    chk_int("rst_mag",   int'(mag_out),   0, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pulse(vecs[i].x, vecs[i].y, lat, ang, mag);
      chk_int($sformatf("vec%0d_latency", i), lat, LAT, 0);
      chk_int($sformatf("vec%0d_angle", i), ang, vecs[i].ang, vecs[i].atol);
      chk_int($sformatf("vec%0d_mag", i), mag, COMP ? vecs[i].mag_comp : vecs[i].mag_raw, vecs[i].mtol);
      @(posedge clk); #1;
      chk_int($sformatf("vec%0d_single_valid", i), int'(valid_out), 0, 0);
    end

    // Streaming: enable dropped every 5th cycle, garbage on x/y during bubbles
    seen = 1'b0; la = 0; lm = 0; issued = 0;
    for (int c = 0; c < NCYC; c++) begin
      xr = int'($urandom_range(32767)) - 16384;
      yr = int'($urandom_range(32767)) - 16384;
      en_h[c] = (c % 5 != 4) && (issued < 64);
      ea[c] = 0; em[c] = 0;
      if (en_h[c]) begin
        for (int t = 0; t < 50 && (xr * xr + yr * yr) < 4096 * 4096; t++) begin
          xr = int'($urandom_range(32767)) - 16384;
          yr = int'($urandom_range(32767)) - 16384;
        end
        ea[c] = int'($atan2(real'(yr), real'(xr)) * 4096.0);
        em[c] = int'($sqrt(real'(xr * xr + yr * yr)) * (COMP ? 1.0 : K_GAIN));
        issued++;
      end
      x_in = 15'(xr); y_in = 15'(yr); enable_in = en_h[c];
      @(posedge clk); #1;
      d = c - (LAT - 1);
      chk_int("rnd_valid", int'(valid_out), (d >= 0) ? int'(en_h[d]) : 0, 0);
      if (d >= 0 && en_h[d]) begin
        chk_int($sformatf("rnd%0d_angle", d), int'($signed(angle_out)), ea[d], 2);
        chk_int($sformatf("rnd%0d_mag", d), int'(mag_out), em[d], 4);
        la = ea[d]; lm = em[d]; seen = 1'b1;
      end else if (seen) begin
        chk_int("bubble_hold_angle", int'($signed(angle_out)), la, 2);
        chk_int("bubble_hold_mag",   int'(mag_out),            lm, 4);
      end
    end
    enable_in = 1'b0;

    // Mid-stream reset with 10 samples in flight
    for (int i = 0; i < 10; i++) begin
      x_in = 15'(4000 + i * 500); y_in = 15'(8000 - i * 300); enable_in = 1'b1;
      @(posedge clk); #1;
    end
    enable_in = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_int("midrst_valid", int'(valid_out), 0, 0);
    chk_int("midrst_angle", int'(angle_out), 0, 0);
    chk_int("midrst_mag",   int'(mag_out),   0, 0);
    pulse(8192, 8192, lat, ang, mag);
    chk_int("postrst_latency", lat, LAT, 0);
    chk_int("postrst_angle", ang, 3217, 2);
    chk_int("postrst_mag", mag, COMP ? 11585 : 19078, 4);
    d = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(posedge clk); #1;
      if (valid_out) d++;
    end
    chk_int("postrst_no_stale", d, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
